edge_gen: RTL and testbench
===========================

EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of the minimum-width counter and Min_Width input.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port Rise_Req  input  1  request to drive signal high.
REQ-005 SHALL provide port Fall_Req  input  1  request to drive signal low.
REQ-006 SHALL provide port Toggle_Req  input  1  request to invert signal.
REQ-007 SHALL provide port Min_Width  input  CNT_W  minimum cycles signal holds a level after any transition, sampled at the transition.
REQ-008 SHALL provide port signal  output  1  registered generated waveform.
REQ-009 SHALL provide port Busy  output  1  high while the hold interval is running.
REQ-010 SHALL provide port Pending  output  1  high while a deferred request is stored.
REQ-011 SHALL provide port Conflict  output  1  one-cycle pulse on illegal simultaneous requests.
REQ-012 SHALL provide port Drop  output  1  one-cycle pulse when a stored request is overwritten.

Function
REQ-013 SHALL define projected level as the stored pending level if Pending=1, else signal.
REQ-014 SHALL treat a request as effective when it changes the projected level: Rise with projected 0, Fall with projected 1, Toggle always; non-effective requests are ignored silently.
REQ-015 SHALL treat two or more of Rise_Req/Fall_Req/Toggle_Req high in one cycle as a conflict: all ignored, Conflict=1 next cycle.
REQ-016 SHALL implement FSM states IDLE and HOLD; Busy=1 exactly in HOLD.
REQ-017 In IDLE, an effective request SHALL update signal at that clock edge (visible one cycle after the request cycle).
REQ-018 On each transition with Min_Width>=2, SHALL enter HOLD with counter=Min_Width-1; with Min_Width 0 or 1, SHALL remain in IDLE (back-to-back transitions allowed every cycle).
REQ-019 In HOLD, SHALL decrement the counter each cycle; it SHALL NOT change signal while the counter is nonzero.
REQ-020 In HOLD with counter=0: if Pending and pending level differs from signal, SHALL apply it, clear Pending, and reload per REQ-018; otherwise SHALL clear Pending and return to IDLE.
REQ-021 An effective request in HOLD SHALL be stored as pending level (Pending=1 next cycle).
REQ-022 An effective request arriving while Pending=1 SHALL overwrite the stored level and pulse Drop for one cycle.
REQ-023 A request arriving in the same cycle as the HOLD expiry SHALL be evaluated against the projected level before the expiry update and stored, not applied that cycle.
REQ-024 Consequently signal SHALL never hold a level for fewer than max(Min_Width,1) cycles.

Reset
REQ-025 On rst=1, SHALL asynchronously force signal=0, Busy=0, Pending=0, Conflict=0, Drop=0, counter=0, state=IDLE, including mid-HOLD.
REQ-026 Requests SHALL be ignored while rst=1; the first honoured request is on the first rising clk edge after rst deasserts.

Configuration
REQ-027 With macro EDGE_GEN_PULSE_EN defined, SHALL add outputs Rise_Pulse and Fall_Pulse (1 bit each), high for exactly the first cycle signal is at its new level after a 0->1 / 1->0 transition; reset value 0.
REQ-028 Without EDGE_GEN_PULSE_EN, those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Min_Width=0, Rise_Req at cycle 3, Fall_Req at cycle 4 -> signal=1 in cycle 4 only, 0 from cycle 5, Busy stays 0.
REQ-030 Min_Width=4, Rise_Req cycle 2, Fall_Req cycle 3 -> signal high cycles 3-6, Pending=1 cycles 4-6, signal low from cycle 7.
REQ-031 Min_Width=4, signal high in HOLD, Fall_Req then Rise_Req on consecutive cycles -> Drop one pulse, final pending level 1, no low transition at expiry.
REQ-032 Rise_Req and Toggle_Req same cycle -> Conflict one pulse, signal unchanged.
REQ-033 rst pulsed mid-HOLD with Pending=1 -> all outputs 0 immediately, no deferred transition after release.
REQ-034 With EDGE_GEN_PULSE_EN, loop signal into an EdgeDet instance -> its Rise_Edge/Fall_Edge match Rise_Pulse/Fall_Pulse count-for-count over 100 random requests.

Source files
------------

// File: rtl/edge_gen.sv
// Waveform generator: rise/fall/toggle requests with a minimum-width hold and one deferred request slot.
// Optional EDGE_GEN_PULSE_EN adds Rise_Pulse/Fall_Pulse outputs.
module edge_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Rise_Req,
  input  logic             Fall_Req,
  input  logic             Toggle_Req,
  input  logic [CNT_W-1:0] Min_Width,
  output logic             signal,
  output logic             Busy,
  output logic             Pending,
  output logic             Conflict,
`ifdef EDGE_GEN_PULSE_EN
  output logic             Rise_Pulse,
  output logic             Fall_Pulse,
`endif
  output logic             Drop
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_q, sig_d;
  logic             pend_q, pend_d;
  logic             plev_q, plev_d;
  logic             conf_q, conf_d;
  logic             drop_q, drop_d;

  logic [1:0] nreq_w;
  logic       proj_w, eff_w, new_lvl_w, expire_w, apply_w, store_w, long_w;

  always_comb begin
    nreq_w    = {1'b0, Rise_Req} + {1'b0, Fall_Req} + {1'b0, Toggle_Req};
    proj_w    = pend_q ? plev_q : sig_q;
    eff_w     = (nreq_w == 2'd1) &&
                ((Rise_Req && !proj_w) || (Fall_Req && proj_w) || Toggle_Req);
    new_lvl_w = Rise_Req || (Toggle_Req && !proj_w);
    expire_w  = (state_q == HOLD) && (cnt_q == '0);
    apply_w   = expire_w && pend_q && (plev_q != sig_q);
    store_w   = (state_q == HOLD) && eff_w;
    long_w    = (Min_Width > CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      pend_q  <= 1'b0;
      plev_q  <= 1'b0;
      conf_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pend_q  <= pend_d;
      plev_q  <= plev_d;
      conf_q  <= conf_d;
      drop_q  <= drop_d;
    end
  end

  // A request stored at expiry keeps HOLD alive with a zero count so it is applied next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (eff_w && long_w) begin
          state_d = HOLD;
          cnt_d   = Min_Width - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!expire_w) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (apply_w && long_w) begin
          cnt_d = Min_Width - CNT_W'(1);
        end else if (eff_w) begin
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sig_d  = sig_q;
    pend_d = pend_q;
    plev_d = plev_q;
    drop_d = 1'b0;
    conf_d = (nreq_w >= 2'd2);
    if ((state_q == IDLE) && eff_w) sig_d = new_lvl_w;
    if (apply_w) sig_d = plev_q;
    if (expire_w) pend_d = 1'b0;
    if (store_w) begin
      pend_d = 1'b1;
      plev_d = new_lvl_w;
      drop_d = pend_q && !apply_w;
    end
  end

  assign signal   = sig_q;
  assign Busy     = (state_q == HOLD);
  assign Pending  = pend_q;
  assign Conflict = conf_q;
  assign Drop     = drop_q;

`ifdef EDGE_GEN_PULSE_EN
  logic rise_p_q, fall_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_p_q <= 1'b0;
      fall_p_q <= 1'b0;
    end else begin
      rise_p_q <= sig_d && !sig_q;
      fall_p_q <= !sig_d && sig_q;
    end
  end

  assign Rise_Pulse = rise_p_q;
  assign Fall_Pulse = fall_p_q;
`endif

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: expected {signal,Busy,Pending,Conflict,Drop} queued per step, popped after the edge.
module tb_edge_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rise_Req = 1'b0, Fall_Req = 1'b0, Toggle_Req = 1'b0;
  logic [7:0] Min_Width = '0;
  logic       signal, Busy, Pending, Conflict, Drop;
`ifdef EDGE_GEN_PULSE_EN
  logic       Rise_Pulse, Fall_Pulse;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  edge_gen #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rise_Req   (Rise_Req),
    .Fall_Req   (Fall_Req),
    .Toggle_Req (Toggle_Req),
    .Min_Width  (Min_Width),
    .signal     (signal),
    .Busy       (Busy),
    .Pending    (Pending),
    .Conflict   (Conflict),
`ifdef EDGE_GEN_PULSE_EN
    .Rise_Pulse (Rise_Pulse),
    .Fall_Pulse (Fall_Pulse),
`endif
    .Drop       (Drop)
  );

  task automatic check_out();
    exp_t       x;
    logic [4:0] obs;
    x   = sb.pop_front();
    obs = {signal, Busy, Pending, Conflict, Drop};
    checks++;
    assert (obs === x.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (sig,busy,pend,conf,drop)", x.tag, obs, x.exp);
    end
  endtask

  // Drive one request cycle, expect the outputs visible after that edge.
  task automatic step(input logic r, input logic f, input logic t, input logic [7:0] mw,
                      input string tag, input logic [4:0] e);
    @(negedge clk);
    Rise_Req = r; Fall_Req = f; Toggle_Req = t; Min_Width = mw;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    Rise_Req = 1'b0; Fall_Req = 1'b0; Toggle_Req = 1'b0;
    check_out();
  endtask

`ifdef EDGE_GEN_PULSE_EN
  logic sig_prev = 1'b0;
  int   ed_rise = 0, ed_fall = 0, dut_rise = 0, dut_fall = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (signal && !sig_prev) ed_rise++;
      if (!signal && sig_prev) ed_fall++;
      if (Rise_Pulse) dut_rise++;
      if (Fall_Pulse) dut_fall++;
    end
    sig_prev <= rst ? 1'b0 : signal;
  end
`endif

  initial begin
    #2;
    sb.push_back('{"reset", 5'b00000});
    check_out();
    @(negedge clk);
    rst = 1'b0;

    // Min_Width 0: back-to-back transitions, never busy
    step(1, 0, 0, 8'd0, "mw0_rise", 5'b10000);
    step(0, 1, 0, 8'd0, "mw0_fall", 5'b00000);
    step(0, 0, 0, 8'd0, "mw0_idle", 5'b00000);

    // Min_Width 1: toggles every cycle
    step(0, 0, 1, 8'd1, "mw1_tog1", 5'b10000);
    step(0, 0, 1, 8'd1, "mw1_tog2", 5'b00000);

    // Min_Width 4: deferred fall applied at expiry
    step(1, 0, 0, 8'd4, "mw4_rise",  5'b11000);
    step(0, 1, 0, 8'd4, "mw4_fall",  5'b11100);
    step(0, 0, 0, 8'd4, "mw4_h2",    5'b11100);
    step(0, 0, 0, 8'd4, "mw4_h3",    5'b11100);
    step(0, 0, 0, 8'd4, "mw4_apply", 5'b01000);
    step(0, 0, 0, 8'd4, "mw4_l1",    5'b01000);
    step(0, 0, 0, 8'd4, "mw4_l2",    5'b01000);
    step(0, 0, 0, 8'd4, "mw4_l3",    5'b01000);
    step(0, 0, 0, 8'd4, "mw4_idle",  5'b00000);

    // Overwrite of pending request: Drop pulse, no transition at expiry
    step(1, 0, 0, 8'd4, "ow_rise",  5'b11000);
    step(0, 1, 0, 8'd4, "ow_fall",  5'b11100);
    step(1, 0, 0, 8'd4, "ow_rise2", 5'b11101);
    step(0, 0, 0, 8'd4, "ow_h",     5'b11100);
    step(0, 0, 0, 8'd4, "ow_exp",   5'b10000);

    // Conflicting requests and a non-effective request
    step(1, 0, 1, 8'd4, "conflict",  5'b10010);
    step(0, 0, 0, 8'd4, "conf_clr",  5'b10000);
    step(1, 0, 0, 8'd4, "noeff_rise", 5'b10000);

    // Request in the expiry cycle is stored, applied one cycle later
    step(0, 1, 0, 8'd2, "ex_fall",  5'b01000);
    step(0, 0, 0, 8'd2, "ex_h",     5'b01000);
    step(1, 0, 0, 8'd2, "ex_store", 5'b01100);
    step(0, 0, 0, 8'd2, "ex_apply", 5'b11000);
    step(0, 0, 0, 8'd2, "ex_h2",    5'b11000);
    step(0, 0, 0, 8'd2, "ex_idle",  5'b10000);

    // Reset mid-HOLD with a pending request
    step(0, 1, 0, 8'd4, "rh_fall", 5'b01000);
    step(1, 0, 0, 8'd4, "rh_rise", 5'b01100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.push_back('{"rst_async", 5'b00000});
    check_out();
    Rise_Req = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{"rst_ignore", 5'b00000});
    check_out();
    @(negedge clk);
    Rise_Req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'd4, "post_rst", 5'b00000);

`ifdef EDGE_GEN_PULSE_EN
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      Rise_Req   = 1'b0; Fall_Req = 1'b0; Toggle_Req = 1'b0;
      Min_Width  = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: Rise_Req = 1'b1;
        1: Fall_Req = 1'b1;
        2: Toggle_Req = 1'b1;
        default: ;
      endcase
    end
    @(negedge clk);
    Rise_Req = 1'b0; Fall_Req = 1'b0; Toggle_Req = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    assert (dut_rise === ed_rise) else begin
      errors++;
      $error("FAIL rise_pulse_count observed=%0d expected=%0d", dut_rise, ed_rise);
    end
    checks++;
    assert (dut_fall === ed_fall) else begin
      errors++;
      $error("FAIL fall_pulse_count observed=%0d expected=%0d", dut_fall, ed_fall);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
